uart_tx_queue: RTL and testbench
================================

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, setting FIFO depth = 2**DEPTH_LOG2 bytes (legal 2..8).
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port wr_en  input  1  producer write strobe, sampled each rising edge.
REQ-005 SHALL have port wr_data  input  8  byte written when wr_en=1.
REQ-006 SHALL have port flush  input  1  synchronous FIFO clear.
REQ-007 SHALL have port full  output  1  FIFO holds 2**DEPTH_LOG2 bytes.
REQ-008 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-009 SHALL have port level  output  DEPTH_LOG2+1  current occupancy.
REQ-010 SHALL have port overflow  output  1  one-cycle pulse, write dropped.
REQ-011 SHALL have port transmit  output  1  one-cycle start strobe to UART transmitter.
REQ-012 SHALL have port tx_byte  output  8  byte presented to UART transmitter.
REQ-013 SHALL have port tx_free  input  1  UART transmit register idle (high = idle).

Function
REQ-014 SHALL store bytes in a circular buffer, read/write pointers DEPTH_LOG2 bits wide, wrapping modulo depth.
REQ-015 SHALL accept a write when wr_en=1 and (full=0 or a pop occurs in the same cycle).
REQ-016 SHALL, on wr_en=1 with full=1 and no same-cycle pop, drop the byte and drive overflow=1 for exactly the next cycle.
REQ-017 SHALL keep level unchanged on simultaneous accepted write and pop.
REQ-018 SHALL derive full, empty and level from registered state only (no combinational path from wr_en).
REQ-019 SHALL, on flush=1, zero pointers and level on that edge; flush wins over a same-cycle write (dropped, no overflow pulse) and over a pop (pop not performed).
REQ-020 SHALL NOT abort an in-flight UART byte on flush; the sequencer completes its current handshake.
REQ-021 SHALL implement sequencer states IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE.
REQ-022 IDLE: if empty=0, tx_free=1, flush=0 -> pop head byte into tx_byte, set transmit=1, go ISSUE; else stay.
REQ-023 ISSUE: transmit=1 for exactly this one cycle; unconditionally go WAIT_ACCEPT with transmit=0.
REQ-024 WAIT_ACCEPT: stay until tx_free=0, then go WAIT_DONE.
REQ-025 WAIT_DONE: stay until tx_free=1, then go IDLE.
REQ-026 SHALL hold tx_byte stable from the ISSUE edge until the next pop.
REQ-027 SHALL give latency: byte written at edge E into empty FIFO with tx_free=1 and sequencer IDLE -> transmit=1 after edge E+1.
REQ-028 SHALL pop exactly once per ISSUE; no byte sent twice or skipped.
REQ-029 SHALL, back-to-back, issue the next byte no earlier than one cycle after tx_free returns high.
REQ-030 SHALL map illegal sequencer encodings to IDLE.

Reset
REQ-031 SHALL on rst=1 immediately force: transmit=0, tx_byte=0, overflow=0, empty=1, full=0, level=0, pointers=0, state IDLE.
REQ-032 SHALL, when reset is released mid-UART-frame, not issue until tx_free=1 (IDLE gating).
REQ-033 SHALL leave memory contents undefined after reset; only pointers are cleared.

Verification
REQ-034 Single byte: write 0xA5 at E, tx_free=1 -> transmit=1 after E+1, tx_byte=0xA5, empty=1, level=0.
REQ-035 Burst: write 0x01..0x10 (DEPTH_LOG2=4) with UART model busy -> full=1, level=16; 17th write 0x11 -> overflow pulse, 0x11 never sent; 0x01..0x10 drain in order.
REQ-036 Full + simultaneous pop and write 0x55 -> no overflow, level stays 16, 0x55 sent last.
REQ-037 Flush during WAIT_DONE with level=5 -> level=0 next cycle, in-flight byte completes, no further transmit.
REQ-038 Async reset asserted in WAIT_ACCEPT between edges -> transmit=0, level=0 without clock edge; after release with tx_free=0, no transmit until tx_free=1.
REQ-039 Random writes vs. UART model (tx_free low 1 cycle after transmit, 10-bit frame) -> output byte stream equals accepted input stream; transmit never high twice without tx_free low-then-high between.

Source files
------------

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter through a four-state start/handshake
// sequencer. The producer pushes bytes with wr_en. The sequencer pops one byte
// per frame and strobes transmit. It then follows tx_free low (frame accepted)
// and high again (frame done) before it may issue the next byte.
module uart_tx_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
  input  logic                  tx_free
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_DEPTH = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    WAIT_ACCEPT = 2'd2,
    WAIT_DONE   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]    level_q, level_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             tx_byte_q, tx_byte_d;
  logic [7:0]             mem [DEPTH];
  logic                   pop, push;

  // Status flags come only from the registered occupancy, never from wr_en.
  assign full     = (level_q == LVL_DEPTH);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = overflow_q;
  assign transmit = (state_q == ISSUE);
  assign tx_byte  = tx_byte_q;

  // Sequencer next state. A pop happens only on the IDLE -> ISSUE transition.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path through
    // the case can leave a signal unassigned and infer a latch.
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && tx_free && !flush) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:       state_d = WAIT_ACCEPT;
      WAIT_ACCEPT: if (!tx_free) state_d = WAIT_DONE;
      WAIT_DONE:   if (tx_free)  state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // FIFO pointer, occupancy and overflow next state. Flush overrides both
  // the write and the pop.
  always_comb begin
    push       = wr_en && !flush && (!full || pop);
    overflow_d = wr_en && !flush && full && !pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    tx_byte_d  = pop ? mem[rd_ptr_q] : tx_byte_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its pre-edge value regardless of statement order.
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  // Byte storage written at the write pointer.
  // NOTE: the memory has no reset. Its contents are only meaningful between
  // the pointers, and a reset here would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue (DEPTH_LOG2 = 4). It runs a vector table
// for the basic issue/handshake flow, then hand-written burst/overflow, flush,
// async-reset and randomised-stream sequences.
module tb_uart_tx_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       tx_free;

  int checks = 0;
  int errors = 0;

  uart_tx_queue #(.DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .transmit (transmit),
    .tx_byte  (tx_byte),
    .tx_free  (tx_free)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       tx_free;
    logic       exp_transmit;
    logic [7:0] exp_tx_byte;
    logic       exp_empty;
    logic       exp_full;
    logic [4:0] exp_level;
    logic       exp_overflow;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  // Handshake monitor: a second transmit must be preceded by tx_free going
  // low and then high again. It also counts overflow pulses.
  int hs_viol = 0;
  int ovf_cnt = 0;
  bit hs_ok = 1'b1;
  bit hs_low = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      hs_ok  = 1'b1;
      hs_low = 1'b0;
    end else begin
      if (overflow) ovf_cnt++;
      if (transmit) begin
        if (!hs_ok) hs_viol++;
        hs_ok  = 1'b0;
        hs_low = 1'b0;
      end else begin
        if (!tx_free) hs_low = 1'b1;
        if (tx_free && hs_low) hs_ok = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve n UART frames. Each frame waits (bounded) for transmit, records
  // tx_byte, holds tx_free low for a 10-cycle frame, then releases it.
  logic [7:0] got_q [$];
  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      int waited = 0;
      while (!transmit && waited < 50) begin
        step();
        waited++;
      end
      if (!transmit) begin
        check("drain timeout", 32'(waited), 32'(0));
        return;
      end
      got_q.push_back(tx_byte);
      tx_free = 1'b0;
      repeat (10) step();
      tx_free = 1'b1;
      step();
    end
  endtask

  logic [7:0] exp_q [$];
  logic [7:0] rnd_got [$];
  bit         prod_done;
  int         tcount;

  initial begin
    // Table: single byte, handshake walk, write during WAIT_DONE, re-issue.
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 5'd0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 5'd0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 5'd0, 1'b0};
    vecs[4]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 5'd0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 5'd0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 5'd0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 5'd0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 5'd0, 1'b0};

    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; tx_free = 1'b1;
    #12;
    check("reset transmit", 32'(transmit), 32'(0));
    check("reset tx_byte",  32'(tx_byte),  32'(0));
    check("reset overflow", 32'(overflow), 32'(0));
    check("reset empty",    32'(empty),    32'(1));
    check("reset full",     32'(full),     32'(0));
    check("reset level",    32'(level),    32'(0));
    step();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data;
      flush = vecs[i].flush; tx_free = vecs[i].tx_free;
      step();
      check($sformatf("vec%0d transmit", i), 32'(transmit), 32'(vecs[i].exp_transmit));
      check($sformatf("vec%0d tx_byte", i),  32'(tx_byte),  32'(vecs[i].exp_tx_byte));
      check($sformatf("vec%0d empty", i),    32'(empty),    32'(vecs[i].exp_empty));
      check($sformatf("vec%0d full", i),     32'(full),     32'(vecs[i].exp_full));
      check($sformatf("vec%0d level", i),    32'(level),    32'(vecs[i].exp_level));
      check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].exp_overflow));
    end
    wr_en = 1'b0;

    // Burst into a busy UART: fill, overflow, then a write alongside a pop at full.
    tx_free = 1'b0;
    wr_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_data = 8'(i);
      step();
    end
    check("burst full",  32'(full),     32'(1));
    check("burst level", 32'(level),    32'(16));
    check("burst no ovf", 32'(overflow), 32'(0));
    wr_data = 8'h11;
    step();
    check("ovf pulse",       32'(overflow), 32'(1));
    check("ovf level",       32'(level),    32'(16));
    wr_data = 8'h55; tx_free = 1'b1;
    step();
    wr_en = 1'b0;
    check("pushpop no ovf",   32'(overflow), 32'(0));
    check("pushpop level",    32'(level),    32'(16));
    check("pushpop transmit", 32'(transmit), 32'(1));
    check("pushpop tx_byte",  32'(tx_byte),  32'(8'h01));
    got_q.delete();
    drain(17);
    check("burst count", 32'(got_q.size()), 32'(17));
    for (int i = 0; i < 17 && i < got_q.size(); i++) begin
      check($sformatf("burst byte%0d", i), 32'(got_q[i]),
            (i < 16) ? 32'(i + 1) : 32'(8'h55));
    end
    check("burst drained empty", 32'(empty), 32'(1));
    tcount = 0;
    repeat (5) begin step(); if (transmit) tcount++; end
    check("burst no extra tx", 32'(tcount), 32'(0));

    // Flush while WAIT_DONE with level 5, plus a same-cycle write that must drop.
    tx_free = 1'b0; wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'(8'h20 + i);
      step();
    end
    wr_en = 1'b0; tx_free = 1'b1;
    step();
    check("flush pre tx",      32'(tx_byte), 32'(8'h20));
    tx_free = 1'b0;
    step(); step();
    check("flush pre level",   32'(level), 32'(5));
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    step();
    flush = 1'b0; wr_en = 1'b0;
    check("flush level",    32'(level),    32'(0));
    check("flush empty",    32'(empty),    32'(1));
    check("flush no ovf",   32'(overflow), 32'(0));
    repeat (3) step();
    tx_free = 1'b1;
    tcount = 0;
    repeat (6) begin step(); if (transmit) tcount++; end
    check("flush no further tx", 32'(tcount), 32'(0));
    check("flush tx_byte held",  32'(tx_byte), 32'(8'h20));

    // Flush beats a pop in IDLE.
    tx_free = 1'b0; wr_en = 1'b1; wr_data = 8'h77;
    step();
    wr_en = 1'b0; tx_free = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    check("flushpop transmit", 32'(transmit), 32'(0));
    check("flushpop level",    32'(level),    32'(0));
    check("flushpop tx_byte",  32'(tx_byte),  32'(8'h20));
    tcount = 0;
    repeat (3) begin step(); if (transmit) tcount++; end
    check("flushpop no tx", 32'(tcount), 32'(0));

    // Async reset between edges while in WAIT_ACCEPT, then release mid-frame.
    tx_free = 1'b0; wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'(8'h30 + i);
      step();
    end
    wr_en = 1'b0; tx_free = 1'b1;
    step();
    check("rst pre transmit", 32'(transmit), 32'(1));
    check("rst pre level",    32'(level),    32'(2));
    step();
    #2 rst = 1'b1;
    #1;
    check("async rst transmit", 32'(transmit), 32'(0));
    check("async rst level",    32'(level),    32'(0));
    check("async rst tx_byte",  32'(tx_byte),  32'(0));
    check("async rst empty",    32'(empty),    32'(1));
    tx_free = 1'b0;
    step(); step();
    rst = 1'b0;
    wr_en = 1'b1; wr_data = 8'h40;
    step();
    wr_en = 1'b0;
    tcount = 0;
    repeat (5) begin step(); if (transmit) tcount++; end
    check("post rst gated", 32'(tcount), 32'(0));
    check("post rst level", 32'(level),  32'(1));
    tx_free = 1'b1;
    step();
    check("post rst transmit", 32'(transmit), 32'(1));
    check("post rst tx_byte",  32'(tx_byte),  32'(8'h40));
    tx_free = 1'b0;
    step(); step();
    tx_free = 1'b1;
    step();

    // Random producer (respecting full) against a UART model.
    prod_done = 1'b0;
    fork
      begin
        repeat (80) begin
          @(posedge clk); #1;
          if (!full && ($urandom_range(0, 1) == 1)) begin
            wr_en = 1'b1;
            wr_data = 8'($urandom);
            exp_q.push_back(wr_data);
          end else begin
            wr_en = 1'b0;
          end
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        prod_done = 1'b1;
      end
      begin
        int cyc = 0;
        while (cyc < 4000 && !(prod_done && rnd_got.size() == exp_q.size())) begin
          @(posedge clk); #1;
          cyc++;
          if (transmit) begin
            rnd_got.push_back(tx_byte);
            tx_free = 1'b0;
            repeat (10) begin @(posedge clk); #1; cyc++; end
            tx_free = 1'b1;
          end
        end
      end
    join
    check("rand count", 32'(rnd_got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rnd_got.size(); i++)
      check($sformatf("rand byte%0d", i), 32'(rnd_got[i]), 32'(exp_q[i]));
    check("rand final empty", 32'(empty), 32'(1));

    step();
    check("handshake violations", 32'(hs_viol), 32'(0));
    check("overflow pulses",      32'(ovf_cnt), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
